exp_range_reduce: RTL and testbench
===================================

// Module: exp_range_reduce
// PURPOSE
//  Range-reduction stage upstream of the exponential evaluator: x = k*ln2 + r.
//  Converts signed fixed-point x into integer k and residual r in [0, ln2), so the
//  series evaluator only sees a small argument and exp(x) = 2^k * exp(r).
//  3-stage valid/ready pipeline; stalls fully under backpressure, drops nothing.
// PARAMETERS
//  DATA_W   32     width of x and r, signed two's complement
//  FRAC_W   16     fractional bits of x and r (default Q16.16)
//  K_W      8      width of signed k; legal range -2^(K_W-1) .. 2^(K_W-1)-1
//  LN2_Q    45426  round(ln2 * 2^FRAC_W)
//  ILN2_Q   94548  round(2^FRAC_W / ln2)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous reset, active low
//  in_valid   in   1       x valid
//  in_ready   out  1       stage 1 can accept
//  in_x       in   DATA_W  signed QDATA_W-FRAC_W.FRAC_W argument
//  out_valid  out  1       k/r/sat valid
//  out_ready  in   1       downstream (exp evaluator) accepts
//  out_k      out  K_W     signed integer exponent
//  out_r      out  DATA_W  residual, 0 <= out_r < LN2_Q
//  out_sat    out  1       k clamped; result not exact
// BEHAVIOUR
//  Reset (async, rst_n=0): all stage valid bits, out_valid, out_k, out_r, out_sat = 0.
//   in_ready undefined-free: reads 1 once valids are 0. Reset mid-operation discards
//   all in-flight items; no output after release until new inputs accepted.
//  Handshake: transfer on valid&&ready at each boundary. out_valid/out_k/out_r/out_sat
//   hold stable while out_valid && !out_ready. in_valid may drop without accept.
//  Stall: en3 = !v3 || out_ready; en2 = !v2 || en3; en1 = !v1 || en2; in_ready = en1
//   (combinational from out_ready; no bubble when full and draining). Stage i loads
//   only when en_i; v_i <= v_{i-1} (or in_valid) on en_i.
//  Latency 3 cycles accept->out_valid with out_ready held 1; throughput 1/cycle.
//  S1: x1 <= in_x; p1 <= in_x * ILN2_Q (full 2*DATA_W signed product).
//  S2: kraw = p1 >>> (2*FRAC_W) (arithmetic shift = floor toward -inf); x2 <= x1.
//  S3: r0 = x2 - kraw*LN2_Q (DATA_W+K_W+2 bit signed); one correction step for
//   constant rounding: r0<0 -> k=kraw-1, r=r0+LN2_Q; r0>=LN2_Q -> k=kraw+1,
//   r=r0-LN2_Q; else k=kraw, r=r0. Correction at most one step.
//  Saturation (checked on corrected k, kraw held wide enough not to wrap):
//   k > 2^(K_W-1)-1 -> out_k = max, out_r = 0, out_sat = 1;
//   k < -2^(K_W-1)  -> out_k = min, out_r = 0, out_sat = 1; else out_sat = 0.
//  Simultaneous out accept and in accept on same cycle: both occur; occupancy const.
// TESTING
//  T1 x=0 -> k=0, r=0, sat=0, out_valid 3 cycles after accept.
//  T2 x=65536 (1.0) -> k=1, r=20110; x=-65536 -> k=-2, r=25316 (floor, not trunc).
//  T3 x=45426 (ln2) -> kraw=0, r0=LN2_Q, corrected to k=1, r=0.
//  T4 x=100.0 (6553600) -> k=127, r=0, sat=1; x=-100.0 -> k=-128, r=0, sat=1.
//  T5 stream 8 inputs, out_ready toggled random 50%: 8 outputs in order, values
//   stable while stalled, in_ready=0 only when all 3 stages full and out_ready=0.
//  T6 rst_n pulsed low with 3 items in flight: out_valid=0 immediately, no stale
//   output after release; next input gives correct result after 3 cycles.

Source files
------------

// File: rtl/exp_range_reduce.sv
// Range reduction for exp(): splits signed fixed-point x into k and r, x = k*ln2 + r,
// 0 <= r < ln2, through a 3-stage valid/ready pipeline that stalls without dropping.
module exp_range_reduce #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int K_W    = 8,
    parameter int LN2_Q  = 45426,
    parameter int ILN2_Q = 94548
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [K_W-1:0]    out_k,
    output logic signed [DATA_W-1:0] out_r,
    output logic                     out_sat
);
    localparam int STAGES = 3;
    localparam int P_W    = 2 * DATA_W;
    localparam int KR_W   = P_W - 2 * FRAC_W;
    localparam int R_W    = DATA_W + K_W + 2;
    localparam int KMAX   = (2 ** (K_W - 1)) - 1;
    localparam int KMIN   = -(2 ** (K_W - 1));

    logic [STAGES:1] vld_pipe;
    logic en1, en2, en3;

    logic signed [DATA_W-1:0] x1, x2;
    logic signed [P_W-1:0]    p1;
    logic signed [KR_W-1:0]   kraw;

    logic signed [R_W-1:0]    r0, rc;
    logic signed [KR_W-1:0]   kc;
    logic                     sat_hi, sat_lo;

    // Enables chain back from the output so a full pipe that is draining takes no bubble.
    assign en3       = !vld_pipe[3] || out_ready;
    assign en2       = !vld_pipe[2] || en3;
    assign en1       = !vld_pipe[1] || en2;
    assign in_ready  = en1;
    assign out_valid = vld_pipe[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            if (en1) vld_pipe[1] <= in_valid;
            if (en2) vld_pipe[2] <= vld_pipe[1];
            if (en3) vld_pipe[3] <= vld_pipe[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1 <= '0;
            p1 <= '0;
        end else if (en1) begin
            x1 <= in_x;
            p1 <= P_W'(in_x) * P_W'(ILN2_Q);
        end
    end

    // Arithmetic shift floors toward -inf, so negative x gets the lower k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x2   <= '0;
            kraw <= '0;
        end else if (en2) begin
            x2   <= x1;
            kraw <= KR_W'(p1 >>> (2 * FRAC_W));
        end
    end

    // The rounded 1/ln2 constant can leave kraw off by one; one fix-up step covers it.
    always_comb begin
        r0 = R_W'(x2) - R_W'(kraw) * R_W'(LN2_Q);
        kc = kraw;
        rc = r0;
        if (r0[R_W-1]) begin
            kc = kraw - KR_W'(1);
            rc = r0 + R_W'(LN2_Q);
        end else if (r0 >= R_W'(LN2_Q)) begin
            kc = kraw + KR_W'(1);
            rc = r0 - R_W'(LN2_Q);
        end
        sat_hi = kc > KR_W'(KMAX);
        sat_lo = kc < KR_W'(KMIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_k   <= '0;
            out_r   <= '0;
            out_sat <= 1'b0;
        end else if (en3) begin
            if (sat_hi) begin
                out_k   <= K_W'(KMAX);
                out_r   <= '0;
                out_sat <= 1'b1;
            end else if (sat_lo) begin
                out_k   <= K_W'(KMIN);
                out_r   <= '0;
                out_sat <= 1'b1;
            end else begin
                out_k   <= K_W'(kc);
                out_r   <= DATA_W'(rc);
                out_sat <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_exp_range_reduce.sv
// Directed bench for exp_range_reduce: hand-computed k/r vectors, latency, backpressure, reset.
module tb_exp_range_reduce;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_x;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_k;
    logic signed [31:0] out_r;
    logic               out_sat;

    int checks = 0;
    int failures = 0;

    exp_range_reduce dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_k(out_k), .out_r(out_r), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // One isolated transfer with out_ready held high; checks latency and result.
    task automatic run_one(input string tag, input int x, input int ek, input int er, input bit es);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = x;
        #1 chk({tag, "_inrdy"}, 64'(in_ready), 64'(1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) in_valid = 1'b0;
        end while (!out_valid && n < 20);
        chk({tag, "_lat"}, 64'(n), 64'(3));
        chk({tag, "_k"},   64'(out_k), 64'(ek));
        chk({tag, "_r"},   64'(out_r), 64'(er));
        chk({tag, "_sat"}, 64'(out_sat), 64'(es));
    endtask

    int sx [8] = '{0, 65536, -65536, 45426, 131072, 32768, -1, 6553600};
    int sk [8] = '{0, 1, -2, 1, 2, 0, -1, 127};
    int sr [8] = '{0, 20110, 25316, 0, 40220, 32768, 45425, 0};
    bit ss [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        int in_idx, out_idx, occ, cyc;
        bit prev_stall;
        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
        #12;
        chk("rst_ovalid", 64'(out_valid), 64'(0));
        chk("rst_k",      64'(out_k), 64'(0));
        chk("rst_r",      64'(out_r), 64'(0));
        chk("rst_sat",    64'(out_sat), 64'(0));
        chk("rst_inrdy",  64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        run_one("t1_zero", 0, 0, 0, 0);
        run_one("t2_one", 65536, 1, 20110, 0);
        run_one("t2_mone", -65536, -2, 25316, 0);
        run_one("t3_ln2", 45426, 1, 0, 0);
        run_one("t3_mln2", -45426, -1, 0, 0);
        run_one("t4_p100", 6553600, 127, 0, 1);
        run_one("t4_m100", -6553600, -128, 0, 1);

        // T5: stream under random backpressure; occupancy model predicts in_ready.
        in_idx = 0; out_idx = 0; occ = 0; cyc = 0; prev_stall = 0;
        while (out_idx < 8 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (in_idx < 8);
            in_x      = (in_idx < 8) ? sx[in_idx] : 0;
            #1;
            chk("t5_inrdy", 64'(in_ready), 64'(!(occ == 3 && !out_ready)));
            if (prev_stall) chk("t5_hold", 64'(out_valid), 64'(1));
            if (out_valid) begin
                chk("t5_k",   64'(out_k), 64'(sk[out_idx]));
                chk("t5_r",   64'(out_r), 64'(sr[out_idx]));
                chk("t5_sat", 64'(out_sat), 64'(ss[out_idx]));
            end
            prev_stall = out_valid && !out_ready;
            if (out_valid && out_ready) begin out_idx++; occ--; end
            if (in_valid && in_ready) begin in_idx++; occ++; end
        end
        chk("t5_count", 64'(out_idx), 64'(8));
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);

        // T6: fill the pipe with out_ready low, then reset mid-flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_x     = 65536 * (i + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("t6_full", 64'(out_valid), 64'(1));
        chk("t6_full_inrdy", 64'(in_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ovalid", 64'(out_valid), 64'(0));
        chk("t6_rst_k",      64'(out_k), 64'(0));
        chk("t6_rst_inrdy",  64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_nostale", 64'(out_valid), 64'(0));
        end
        run_one("t6_after", 65536, 1, 20110, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
